// File: rtl/sr_latch_core_if.sv
// Bundle of set/reset requests and registered status outputs for sr_latch_core.
// The master modport drives requests; the slave modport is the latch bank.
interface sr_latch_core_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] invalid;
    logic [WIDTH-1:0] err_sticky;

    modport master (
        output s,
        output r,
        output err_clr,
        input  q,
        input  qb,
        input  invalid,
        input  err_sticky
    );

    modport slave (
        input  s,
        input  r,
        input  err_clr,
        output q,
        output qb,
        output invalid,
        output err_sticky
    );
endinterface

// File: rtl/sr_latch_core.sv
// Clocked bank of independent SR storage bits with true/complement outputs,
// a registered s=r=1 flag and a sticky error record.
module sr_latch_core #(
    parameter int WIDTH        = 1,
    parameter int INVALID_MODE = 0,
    parameter int RESET_Q      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_latch_core_if.slave    bus
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sr_latch_core: WIDTH must be at least 1");
        end
        if (INVALID_MODE < 0 || INVALID_MODE > 3) begin : g_bad_mode
            $error("sr_latch_core: INVALID_MODE must be 0..3");
        end
        if (RESET_Q < 0 || RESET_Q > 1) begin : g_bad_reset_q
            $error("sr_latch_core: RESET_Q must be 0 or 1");
        end
    endgenerate

    localparam logic RESET_BIT = (RESET_Q != 0) ? 1'b1 : 1'b0;

    // Next {q, qb} for one bit. The hold case also repairs the q=qb=0 state
    // left behind by a NOR-style invalid cycle, so it never persists.
    function automatic logic [1:0] resolve_bit(
        input logic s_bit,
        input logic r_bit,
        input logic q_bit,
        input logic qb_bit
    );
        logic [1:0] nxt;
        nxt = {q_bit, qb_bit};
        case ({s_bit, r_bit})
            2'b00: begin
                if (!q_bit && !qb_bit) begin
                    nxt = 2'b01;
                end
            end
            2'b01: nxt = 2'b01;
            2'b10: nxt = 2'b10;
            default: begin
                case (INVALID_MODE)
                    0:       nxt = 2'b00;
                    1:       nxt = 2'b10;
                    2:       nxt = 2'b01;
                    default: nxt = {q_bit, qb_bit};
                endcase
            end
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] q_p0;
    logic [WIDTH-1:0] qb_p0;
    logic [WIDTH-1:0] invalid_p0;
    logic [WIDTH-1:0] err_p0;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] qb_nxt;
    logic [WIDTH-1:0] both_req;
    logic [WIDTH-1:0] err_nxt;

    always_comb begin
        q_nxt    = q_p0;
        qb_nxt   = qb_p0;
        both_req = bus.s & bus.r;
        for (int i = 0; i < WIDTH; i++) begin
            {q_nxt[i], qb_nxt[i]} = resolve_bit(bus.s[i], bus.r[i], q_p0[i], qb_p0[i]);
        end
        // A fresh s=r=1 sample outranks a simultaneous clear.
        err_nxt = (err_p0 & ~{WIDTH{bus.err_clr}}) | both_req;
    end

    // Stage p0: registered state and status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_p0       <= {WIDTH{RESET_BIT}};
            qb_p0      <= {WIDTH{~RESET_BIT}};
            invalid_p0 <= '0;
            err_p0     <= '0;
        end else begin
            q_p0       <= q_nxt;
            qb_p0      <= qb_nxt;
            invalid_p0 <= both_req;
            err_p0     <= err_nxt;
        end
    end

    assign bus.q          = q_p0;
    assign bus.qb         = qb_p0;
    assign bus.invalid    = invalid_p0;
    assign bus.err_sticky = err_p0;

endmodule

// File: tb/tb_sr_latch_core.sv
// Directed bench for sr_latch_core: four 1-bit instances (one per INVALID_MODE)
// driven in lockstep plus a 4-bit NOR-mode instance.
module tb_sr_latch_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sr_latch_core_if #(.WIDTH(1)) if0 ();
    sr_latch_core_if #(.WIDTH(1)) if1 ();
    sr_latch_core_if #(.WIDTH(1)) if2 ();
    sr_latch_core_if #(.WIDTH(1)) if3 ();
    sr_latch_core_if #(.WIDTH(4)) if4 ();

    sr_latch_core #(.WIDTH(1), .INVALID_MODE(0), .RESET_Q(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    sr_latch_core #(.WIDTH(1), .INVALID_MODE(1), .RESET_Q(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    sr_latch_core #(.WIDTH(1), .INVALID_MODE(2), .RESET_Q(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    sr_latch_core #(.WIDTH(1), .INVALID_MODE(3), .RESET_Q(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    sr_latch_core #(.WIDTH(4), .INVALID_MODE(0), .RESET_Q(0)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    task automatic drive_w1(input logic sv, input logic rv, input logic clr);
        if0.s = sv; if0.r = rv; if0.err_clr = clr;
        if1.s = sv; if1.r = rv; if1.err_clr = clr;
        if2.s = sv; if2.r = rv; if2.err_clr = clr;
        if3.s = sv; if3.r = rv; if3.err_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed status word for 1-bit instances is {q, qb, invalid, err_sticky}.
    task automatic test_reset();
        rst_n = 1'b0;
        drive_w1(1'b1, 1'b1, 1'b1);
        if4.s = 4'hF; if4.r = 4'hF; if4.err_clr = 1'b1;
        tick();
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_w1 got %b expected 0100", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
        vectors++;
        if ({if4.q, if4.qb, if4.invalid, if4.err_sticky} !== 16'h0F00) begin
            miscompares++;
            $display("FAIL reset_w4 got %h expected 0f00", {if4.q, if4.qb, if4.invalid, if4.err_sticky});
        end
        rst_n = 1'b1;
        if4.s = 4'h0; if4.r = 4'h0; if4.err_clr = 1'b0;
    endtask

    task automatic test_set_reset();
        drive_w1(1'b0, 1'b1, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_req got %b expected 0100", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
        drive_w1(1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b1000) begin
            miscompares++;
            $display("FAIL set_req got %b expected 1000", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
    endtask

    task automatic test_hold();
        drive_w1(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({if0.q, if0.qb} !== 2'b10) begin
                miscompares++;
                $display("FAIL hold_set cycle %0d got %b expected 10", i, {if0.q, if0.qb});
            end
        end
        drive_w1(1'b0, 1'b1, 1'b0);
        tick();
        drive_w1(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({if0.q, if0.qb} !== 2'b01) begin
                miscompares++;
                $display("FAIL hold_clr cycle %0d got %b expected 01", i, {if0.q, if0.qb});
            end
        end
    endtask

    task automatic test_invalid_default();
        drive_w1(1'b1, 1'b1, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0011) begin
            miscompares++;
            $display("FAIL invalid_nor got %b expected 0011", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
        drive_w1(1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0101) begin
            miscompares++;
            $display("FAIL invalid_recover got %b expected 0101", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
    endtask

    task automatic test_modes();
        drive_w1(1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({if3.q, if3.qb, if3.invalid, if3.err_sticky} !== 4'b1001) begin
            miscompares++;
            $display("FAIL modes_preset got %b expected 1001", {if3.q, if3.qb, if3.invalid, if3.err_sticky});
        end
        drive_w1(1'b1, 1'b1, 1'b0);
        tick();
        vectors++;
        if ({if1.q, if1.qb, if1.invalid, if1.err_sticky} !== 4'b1011) begin
            miscompares++;
            $display("FAIL mode1_setdom got %b expected 1011", {if1.q, if1.qb, if1.invalid, if1.err_sticky});
        end
        vectors++;
        if ({if2.q, if2.qb, if2.invalid, if2.err_sticky} !== 4'b0111) begin
            miscompares++;
            $display("FAIL mode2_rstdom got %b expected 0111", {if2.q, if2.qb, if2.invalid, if2.err_sticky});
        end
        vectors++;
        if ({if3.q, if3.qb, if3.invalid, if3.err_sticky} !== 4'b1011) begin
            miscompares++;
            $display("FAIL mode3_hold got %b expected 1011", {if3.q, if3.qb, if3.invalid, if3.err_sticky});
        end
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0011) begin
            miscompares++;
            $display("FAIL mode0_nor got %b expected 0011", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
    endtask

    task automatic test_sticky();
        drive_w1(1'b0, 1'b0, 1'b1);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0100) begin
            miscompares++;
            $display("FAIL clr_alone_m0 got %b expected 0100", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
        vectors++;
        if ({if1.q, if1.qb, if1.invalid, if1.err_sticky} !== 4'b1000) begin
            miscompares++;
            $display("FAIL clr_alone_m1 got %b expected 1000", {if1.q, if1.qb, if1.invalid, if1.err_sticky});
        end
        drive_w1(1'b1, 1'b1, 1'b1);
        tick();
        vectors++;
        if ({if2.q, if2.qb, if2.invalid, if2.err_sticky} !== 4'b0111) begin
            miscompares++;
            $display("FAIL clr_vs_set got %b expected 0111", {if2.q, if2.qb, if2.invalid, if2.err_sticky});
        end
        drive_w1(1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0101) begin
            miscompares++;
            $display("FAIL err_held got %b expected 0101", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
    endtask

    task automatic test_width4();
        if4.s = 4'b0101; if4.r = 4'b0011; if4.err_clr = 1'b0;
        tick();
        vectors++;
        if ({if4.q, if4.qb, if4.invalid, if4.err_sticky} !== 16'b0100_1010_0001_0001) begin
            miscompares++;
            $display("FAIL width4_mix got %b expected 0100101000010001", {if4.q, if4.qb, if4.invalid, if4.err_sticky});
        end
        if4.s = 4'b0000; if4.r = 4'b0000;
        tick();
        vectors++;
        if ({if4.q, if4.qb, if4.invalid, if4.err_sticky} !== 16'b0100_1011_0000_0001) begin
            miscompares++;
            $display("FAIL width4_recover got %b expected 0100101100000001", {if4.q, if4.qb, if4.invalid, if4.err_sticky});
        end
    endtask

    task automatic test_back_to_back();
        drive_w1(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0011) begin
                miscompares++;
                $display("FAIL b2b_invalid cycle %0d got %b expected 0011", i, {if0.q, if0.qb, if0.invalid, if0.err_sticky});
            end
        end
        drive_w1(1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b1001) begin
            miscompares++;
            $display("FAIL b2b_then_set got %b expected 1001", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
    endtask

    task automatic test_reset_override();
        rst_n = 1'b0;
        drive_w1(1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({if0.q, if0.qb, if0.invalid, if0.err_sticky} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_override got %b expected 0100", {if0.q, if0.qb, if0.invalid, if0.err_sticky});
        end
        vectors++;
        if ({if4.q, if4.qb, if4.invalid, if4.err_sticky} !== 16'h0F00) begin
            miscompares++;
            $display("FAIL reset_override_w4 got %h expected 0f00", {if4.q, if4.qb, if4.invalid, if4.err_sticky});
        end
        rst_n = 1'b1;
    endtask

    initial begin
        drive_w1(1'b0, 1'b0, 1'b0);
        if4.s = 4'h0; if4.r = 4'h0; if4.err_clr = 1'b0;
        #2;
        test_reset();
        test_set_reset();
        test_hold();
        test_invalid_default();
        test_modes();
        test_sticky();
        test_width4();
        test_back_to_back();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_latch_core.md
Name:
sr_latch_core

Overview:
- Synchronous, clocked model of a bank of WIDTH independent set/reset storage bits with true and complement outputs.
- Per-bit set (s) and reset (r) requests are sampled on the rising clock edge and update q/qb.
- Flags the illegal s=r=1 combination, resolves it according to a parameter, and keeps a sticky error record.
- Used as a glitch-free, reset-defined replacement for a cross-coupled NOR latch inside control/status logic.

Parameters:
- WIDTH, 1, number of independent SR bits.
- INVALID_MODE, 0, s=r=1 resolution: 0 = NOR-style (q=0 and qb=0), 1 = set-dominant, 2 = reset-dominant, 3 = hold previous state.
- RESET_Q, 0, value loaded into every q bit on reset (qb loads ~RESET_Q).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- s  input  WIDTH  per-bit set request.
- r  input  WIDTH  per-bit reset request.
- err_clr  input  1  clears the sticky error register.
- q  output  WIDTH  stored state.
- qb  output  WIDTH  complement output; equals ~q except as defined for INVALID_MODE 0.
- invalid  output  WIDTH  per-bit, registered; 1 for the cycle after s=r=1 was sampled on that bit.
- err_sticky  output  WIDTH  per-bit, set on any sampled s=r=1, held until cleared.

Behaviour:
- All state updates occur only on the rising edge of clk. Outputs are registered with 1-cycle latency and have no combinational path from inputs.
- Reset: rst_n=0 at a clock edge forces q=RESET_Q, qb=~RESET_Q, invalid=0 and err_sticky=0. Reset overrides all inputs, including s=r=1 and err_clr.
- Per bit i, when rst_n=1:
  - s=0, r=0: hold. q and qb keep their values. If the previous cycle left q=qb=0 (INVALID_MODE 0), the bit resolves to q=0, qb=1.
  - s=0, r=1: q=0, qb=1.
  - s=1, r=0: q=1, qb=0.
  - s=1, r=1 with INVALID_MODE 0: q=0, qb=0. INVALID_MODE 1: q=1, qb=0. INVALID_MODE 2: q=0, qb=1. INVALID_MODE 3: hold.
- invalid[i] is 1 for exactly the cycle following each edge that sampled s[i]=r[i]=1, and is asserted in every INVALID_MODE.
- err_sticky[i] is set by s[i]=r[i]=1. err_clr=1 clears all bits. If err_clr=1 and s=r=1 occur in the same cycle, set wins.
- Bits are fully independent; no cross-bit interaction.
- qb never equals q=1 together with qb=1.
- Inputs are not re-synchronised. They must meet setup/hold to clk.
- INVALID_MODE or RESET_Q values outside their defined range are a parameter error (elaboration-time check).

Test Plan:
- Reset: rst_n=0 for 2 cycles with s=r=1 -> q=0, qb=1, invalid=0, err_sticky=0 (RESET_Q=0).
- Reset then set: s=0,r=1 -> q=0,qb=1. Next s=1,r=0 -> q=1,qb=0 one cycle later.
- Hold: after set, s=0,r=0 for 5 cycles -> q=1,qb=0 unchanged. After reset, hold -> q=0,qb=1.
- Invalid, default mode: s=1,r=1 -> next cycle q=0,qb=0,invalid=1,err_sticky=1. Then s=0,r=0 -> q=0,qb=1,invalid=0,err_sticky=1.
- Modes 1/2/3 with q=1 beforehand and s=r=1: mode 1 gives q=1,qb=0; mode 2 gives q=0,qb=1; mode 3 gives q=1,qb=0. invalid=1 in all three.
- Sticky error: err_clr=1 alone -> err_sticky=0. err_clr=1 with s=r=1 -> err_sticky=1. WIDTH=4 with s=4'b0101, r=4'b0011 -> q=4'b0100 (bit0 per mode), invalid=4'b0001.
